// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone port-B bridge to the J1 program/data RAM.
// Holds the FSM state encoding and the byte-lane merge used by read-modify-write.
package wb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RMW_RD,
      RMW_WR,
      ACK
   } state_e;

   // The merge works on a 64-bit container; callers zero-extend and truncate.
   localparam int MERGE_W     = 64;
   localparam int MERGE_SEL_W = MERGE_W / 8;

   function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0]     old_w,
                                                input logic [MERGE_W-1:0]     new_w,
                                                input logic [MERGE_SEL_W-1:0] sel);
      logic [MERGE_W-1:0] res;
      for (int i = 0; i < MERGE_SEL_W; i++) begin
         res[i*8 +: 8] = sel[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_dpram_port.sv
// Wishbone B4 classic slave driving port B of the dual-port RAM; partial-lane
// writes are done as read-modify-write because the RAM has no byte enables.
module wb_dpram_port
   import wb_pkg::*;
#(
   parameter  int ADDR_W = 13,
   parameter  int DATA_W = 16,
   localparam int SEL_W  = DATA_W / 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [SEL_W-1:0]  wb_sel_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic              wb_ack_o,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] merge_q, merge_d;
   logic [DATA_W-1:0] rdat_q, rdat_d;
   logic              ack_q, ack_d;
   logic              wren;
   logic              req;
   logic              sel_full;
   logic              sel_none;

   assign req      = wb_cyc_i & wb_stb_i;
   assign sel_full = &wb_sel_i;
   assign sel_none = ~|wb_sel_i;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d     = state_q;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      sel_d       = sel_q;
      merge_d     = merge_q;
      rdat_d      = rdat_q;
      ack_d       = 1'b0;
      wren        = 1'b0;
      ram_address = adr_q;
      ram_data    = merge_q;

      unique case (state_q)
         IDLE: begin
            ram_address = wb_adr_i;
            ram_data    = wb_dat_i;
            if (req) begin
               if (!wb_we_i) begin
                  adr_d   = wb_adr_i;
                  state_d = RD;
               end else if (sel_full) begin
                  wren    = 1'b1;
                  ack_d   = 1'b1;
                  state_d = ACK;
               end else if (sel_none) begin
                  ack_d   = 1'b1;
                  state_d = ACK;
               end else begin
                  adr_d   = wb_adr_i;
                  wdat_d  = wb_dat_i;
                  sel_d   = wb_sel_i;
                  state_d = RMW_RD;
               end
            end
         end
         RD: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else begin
               rdat_d  = ram_q;
               ack_d   = 1'b1;
               state_d = ACK;
            end
         end
         RMW_RD: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else begin
               merge_d = DATA_W'(merge(MERGE_W'(ram_q), MERGE_W'(wdat_q), MERGE_SEL_W'(sel_q)));
               state_d = RMW_WR;
            end
         end
         RMW_WR: begin
            // The write is committed even if the master aborts now; only the ack is dropped.
            wren    = 1'b1;
            ack_d   = wb_cyc_i;
            state_d = wb_cyc_i ? ACK : IDLE;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: the state register uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         wdat_q  <= '0;
         sel_q   <= '0;
         merge_q <= '0;
         rdat_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         sel_q   <= sel_d;
         merge_q <= merge_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
      end
   end

   // The IDLE full-write path is combinational from the bus, so it must be gated while in reset.
   assign ram_wren = wren & reset_n;
   assign wb_ack_o = ack_q;
   assign wb_dat_o = rdat_q;

endmodule

// File: doc/wb_dpram_port.md
Name: wb_dpram_port

Overview:
- Wishbone B4 classic slave that drives port B of the 8Kx16 dual-port program/data RAM, so a bus master (debug loader, DMA) can read and write J1 memory while the core uses port A.
- Handles the RAM's 1-cycle registered read latency.
- Implements byte-lane writes as read-modify-write, because the RAM has no byte enables.

Parameters:
- ADDR_W, 13, word-address width; RAM depth is 2**ADDR_W.
- DATA_W, 16, data width; must be a multiple of 8. SEL_W = DATA_W/8 is derived and is not overridable.

Ports:
- clock  in  1  single clock, shared with the RAM
- reset_n  in  1  asynchronous, active-low reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  ADDR_W  word address
- wb_sel_i  in  SEL_W  byte selects; sel[0] covers bits 7:0
- wb_dat_i  in  DATA_W  write data
- wb_dat_o  out  DATA_W  read data, registered
- wb_ack_o  out  1  acknowledge, registered, one cycle per transfer
- ram_address  out  ADDR_W  to RAM address_b
- ram_data  out  DATA_W  to RAM data_b
- ram_wren  out  1  to RAM wren_b
- ram_q  in  DATA_W  from RAM q_b; valid one cycle after the address is sampled

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; wb_ack_o=0; wb_dat_o=0; adr_q=0; merge_q=0.
  - ram_wren=0 while reset_n is low.
- Request = wb_cyc_i & wb_stb_i, sampled only in IDLE.
- ram_address = wb_adr_i in IDLE, adr_q in all other states.
- ram_wren is combinational and is 1 only in:
  - IDLE with a full write;
  - RMW_WR.
- States:
  - IDLE:
    - Read request: adr_q<=adr; go to RD. The RAM captures the address on the same edge.
    - Write request with sel all-ones: ram_wren=1, ram_data=wb_dat_i; the RAM writes on this edge; wb_ack_o<=1; go to ACK. Latency: ack 1 cycle after request.
    - Write request with sel all-zero: no RAM write; wb_ack_o<=1; go to ACK.
    - Write request with partial sel: adr_q<=adr; capture wb_dat_i and sel; go to RMW_RD.
  - RD: wb_dat_o<=ram_q; wb_ack_o<=1; go to ACK. Latency: ack 2 cycles after request.
  - RMW_RD: merge_q<=per byte lane (sel ? wb_dat_i : ram_q); go to RMW_WR.
  - RMW_WR: ram_wren=1, ram_data=merge_q; wb_ack_o<=1; go to ACK. Latency: ack 3 cycles after request.
  - ACK: wb_ack_o<=0; go to IDLE.
    - Back-to-back requests are therefore separated by at least one idle-sampled cycle.
- wb_dat_o holds its last read value until the next read completes. Writes do not alter it.
- Abort (wb_cyc_i low in RD or RMW_RD):
  - Go to IDLE with no ack and no RAM write.
  - Abort observed in RMW_WR: the write still completes (atomic), ack is suppressed, go to IDLE.
- wb_stb_i dropping while wb_cyc_i stays high after a request is accepted is a master protocol violation. The block completes the transfer normally.
- Reset asserted mid-transfer: FSM to IDLE immediately; no ack. A write is lost unless its RAM edge has already occurred. RAM contents are not cleared.
- Port-A/port-B same-address collisions: arbitration belongs to software. Read data is undefined on a same-cycle write by port A. A port-A write between RMW_RD and RMW_WR is overwritten (documented limitation).
- The address wraps implicitly at 2**ADDR_W; no error response.

Decomposition:
- Shared package wb_pkg holds:
  - state enum {IDLE, RD, RMW_RD, RMW_WR, ACK};
  - the byte-lane merge function merge(old, new, sel).
- No sub-module is needed; the RAM is instantiated by the parent alongside this block.

Test Plan:
- Reset, then full write adr=0x0123 dat=0xBEEF sel=11 -> ram_wren high in IDLE cycle; ack 1 cycle later. Read 0x0123 -> ack 2 cycles after request, wb_dat_o=0xBEEF.
- Preload 0x1FFF=0x1234; write dat=0xAB00 sel=10 -> ack at cycle 3; read back 0xAB34. Then sel=01 dat=0x00CD -> 0xABCD.
- Write sel=00 to 0x0010 holding 0x5555 -> ack after 1 cycle; readback 0x5555; ram_wren never asserted.
- Back-to-back: read 0x0001 then write 0x0002 with stb held high -> exactly one ack per transfer, ack never high two consecutive cycles, both transfers correct.
- Abort: partial write to 0x0020 (old 0x0F0F), drop cyc in RMW_RD -> no ack, ram_wren stays 0, memory stays 0x0F0F. Drop cyc in RMW_WR -> memory updated, no ack.
- Assert reset_n=0 during RD -> wb_ack_o=0 and wb_dat_o=0 immediately; after release, a new read of 0x0123 returns 0xBEEF (RAM contents preserved).
